// File: rtl/uart_peripheral_if.sv
// Memory-bus port of the UART: one-cycle strobed accesses, registered read data.
interface uart_peripheral_if;
  logic        bus_enable;
  logic        write_enable;
  logic [3:0]  address;
  logic [31:0] data_in;
  logic [3:0]  write_mask;
  logic [31:0] data_out;

  modport master (output bus_enable, write_enable, address, data_in, write_mask,
                  input  data_out);
  modport slave  (input  bus_enable, write_enable, address, data_in, write_mask,
                  output data_out);
endinterface

// File: rtl/uart_peripheral.sv
// 8N1 UART target on the CPU memory bus: TX FIFO + shifter, single-byte RX
// holding register, status with write-1-to-clear error bits, baud divisor.
module uart_peripheral #(
  parameter int DEFAULT_DIVISOR = 104,
  parameter int TX_FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_peripheral_if.slave  bus,
  output logic              uart_tx,
  input  logic              uart_rx
);
  localparam int AW = $clog2(TX_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

  // ---------------- bus decode ----------------
  logic [1:0] reg_sel;
  logic       rd_acc, wr_acc, lane0_wr, lane1_wr;
  assign reg_sel  = bus.address[3:2];
  assign rd_acc   = bus.bus_enable & ~bus.write_enable;
  assign wr_acc   = bus.bus_enable &  bus.write_enable;
  assign lane0_wr = wr_acc & ~bus.write_mask[0];
  assign lane1_wr = wr_acc & ~bus.write_mask[1];

  logic unused_bits;
  assign unused_bits = ^{bus.address[1:0], bus.data_in[31:16], bus.write_mask[3:2]};

  // ---------------- divisor ----------------
  logic [15:0] div_q, bit_time, half_time;
  assign bit_time  = (div_q < 16'd2) ? 16'd2 : div_q;
  assign half_time = bit_time >> 1;

  // Divisor register, byte-lane writable; counters reload from it only at bit boundaries
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) div_q <= 16'(DEFAULT_DIVISOR);
    else if (reg_sel == 2'd3) begin
      if (lane0_wr) div_q[7:0]  <= bus.data_in[7:0];
      if (lane1_wr) div_q[15:8] <= bus.data_in[15:8];
    end

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, fifo_push, fifo_pop;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Full is judged before this cycle's pop, so a push into a full FIFO is dropped
  assign fifo_push  = lane0_wr && (reg_sel == 2'd0) && !fifo_full;

  // FIFO pointers; extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
    end

  // FIFO storage, no reset needed
  always_ff @(posedge clk)
    if (fifo_push) fifo_mem[wr_ptr[AW-1:0]] <= bus.data_in[7:0];

  // ---------------- transmitter ----------------
  ser_state_t  tx_state, tx_state_d;
  logic [15:0] tx_cnt, tx_cnt_d;
  logic [2:0]  tx_bit, tx_bit_d;
  logic [7:0]  tx_sh, tx_sh_d;
  logic        tx_line, tx_line_d, tx_next_frame;
  logic        tx_idle;
  assign tx_idle = fifo_empty && (tx_state == S_IDLE);
  assign uart_tx = tx_line;

  // TX state register; line is registered so reset forces it high immediately
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
      tx_line  <= tx_line_d;
    end

  // TX next state: one down-counted bit time per START/DATA/STOP bit
  always_comb begin
    tx_state_d    = tx_state;
    tx_cnt_d      = tx_cnt;
    tx_bit_d      = tx_bit;
    tx_sh_d       = tx_sh;
    tx_line_d     = tx_line;
    tx_next_frame = 1'b0;
    fifo_pop      = 1'b0;
    case (tx_state)
      S_IDLE:  tx_next_frame = 1'b1;
      S_START: if (tx_cnt == '0) begin
                 tx_state_d = S_DATA;
                 tx_cnt_d   = bit_time - 16'd1;
                 tx_bit_d   = '0;
                 tx_line_d  = tx_sh[0];
               end else tx_cnt_d = tx_cnt - 16'd1;
      S_DATA:  if (tx_cnt == '0) begin
                 tx_cnt_d = bit_time - 16'd1;
                 tx_sh_d  = {1'b0, tx_sh[7:1]};
                 tx_bit_d = tx_bit + 3'd1;
                 if (tx_bit == 3'd7) begin
                   tx_state_d = S_STOP;
                   tx_line_d  = 1'b1;
                 end else tx_line_d = tx_sh[1];
               end else tx_cnt_d = tx_cnt - 16'd1;
      S_STOP:  if (tx_cnt == '0) begin
                 tx_state_d    = S_IDLE;
                 tx_next_frame = 1'b1;
               end else tx_cnt_d = tx_cnt - 16'd1;
      default: tx_state_d = S_IDLE;
    endcase
    // Start the next frame straight from IDLE or the end of STOP (no gap bit)
    if (tx_next_frame && !fifo_empty) begin
      fifo_pop   = 1'b1;
      tx_sh_d    = fifo_mem[rd_ptr[AW-1:0]];
      tx_cnt_d   = bit_time - 16'd1;
      tx_line_d  = 1'b0;
      tx_state_d = S_START;
    end
  end

  // ---------------- receiver ----------------
  logic [1:0] rx_sync;
  logic       rx_s, rx_prev;
  assign rx_s = rx_sync[1];

  // Two-flop synchronizer plus delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
    end

  ser_state_t  rx_state, rx_state_d;
  logic [15:0] rx_cnt, rx_cnt_d;
  logic [2:0]  rx_bit, rx_bit_d;
  logic [7:0]  rx_sh, rx_sh_d;
  logic        rx_done, rx_ferr_set;

  // RX state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
    end

  // RX next state: half-bit wait to mid start bit, then sample every bit time
  always_comb begin
    rx_state_d  = rx_state;
    rx_cnt_d    = rx_cnt;
    rx_bit_d    = rx_bit;
    rx_sh_d     = rx_sh;
    rx_done     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state)
      S_IDLE:  if (rx_prev && !rx_s) begin
                 rx_state_d = S_START;
                 rx_cnt_d   = half_time - 16'd1;
               end
      S_START: if (rx_cnt == '0) begin
                 rx_state_d = rx_s ? S_IDLE : S_DATA;
                 rx_cnt_d   = bit_time - 16'd1;
                 rx_bit_d   = '0;
               end else rx_cnt_d = rx_cnt - 16'd1;
      S_DATA:  if (rx_cnt == '0) begin
                 rx_sh_d  = {rx_s, rx_sh[7:1]};
                 rx_bit_d = rx_bit + 3'd1;
                 rx_cnt_d = bit_time - 16'd1;
                 if (rx_bit == 3'd7) rx_state_d = S_STOP;
               end else rx_cnt_d = rx_cnt - 16'd1;
      S_STOP:  if (rx_cnt == '0) begin
                 rx_state_d  = S_IDLE;
                 rx_done     = rx_s;
                 rx_ferr_set = !rx_s;
               end else rx_cnt_d = rx_cnt - 16'd1;
      default: rx_state_d = S_IDLE;
    endcase
  end

  // ---------------- RX holding / status ----------------
  logic       rx_valid, rx_overrun, rx_frame_err;
  logic [7:0] rx_byte;
  logic       rx_pop, sts_w1c;
  assign rx_pop  = rd_acc && (reg_sel == 2'd1) && rx_valid;
  assign sts_w1c = lane0_wr && (reg_sel == 2'd2);

  // Holding register: a read in the completion cycle frees the slot for the new byte;
  // a freshly detected error beats a simultaneous clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rx_valid     <= 1'b0;
      rx_byte      <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_done && (!rx_valid || rx_pop)) begin
        rx_valid <= 1'b1;
        rx_byte  <= rx_sh;
      end else if (rx_pop) rx_valid <= 1'b0;
      rx_overrun   <= (rx_overrun & ~(sts_w1c & bus.data_in[3])) | (rx_done & rx_valid & ~rx_pop);
      rx_frame_err <= (rx_frame_err & ~(sts_w1c & bus.data_in[4])) | rx_ferr_set;
    end

  // Registered read data, updated only by reads
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) bus.data_out <= '0;
    else if (rd_acc)
      case (reg_sel)
        2'd0:    bus.data_out <= '0;
        2'd1:    bus.data_out <= {23'b0, rx_valid, rx_byte};
        2'd2:    bus.data_out <= {27'b0, rx_frame_err, rx_overrun, rx_valid, tx_idle, fifo_full};
        default: bus.data_out <= {16'b0, div_q};
      endcase
endmodule

// File: tb/tb_uart_peripheral.sv
// Scoreboard bench for uart_peripheral: expected read data and TX frames are
// queued at issue time and popped by independent monitors.
module tb_uart_peripheral;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic uart_tx;
  logic uart_rx;

  uart_peripheral_if bus ();

  uart_peripheral #(.DEFAULT_DIVISOR(104), .TX_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  // ---------------- read scoreboard ----------------
  string       rd_name_q[$];
  logic [31:0] rd_exp_q[$];
  logic        rd_seen = 1'b0;

  always @(posedge clk) rd_seen <= bus.bus_enable && !bus.write_enable;

  // data_out must carry the answer in the cycle right after the strobe
  always @(negedge clk)
    if (rd_seen) begin
      if (rd_exp_q.size() == 0) fail_now("rd_unexpected");
      else check(rd_name_q.pop_front(), bus.data_out, rd_exp_q.pop_front());
    end

  // ---------------- TX scoreboard ----------------
  logic [7:0] tx_exp_q[$];
  int         bt_tb;
  bit         mon_off;

  initial begin : tx_mon
    logic       prev;
    logic [9:0] fr;
    int         bt;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!mon_off && prev && !uart_tx) begin
        bt = bt_tb;
        repeat (bt / 2) @(negedge clk);
        fr[0] = uart_tx;
        for (int k = 1; k < 10; k++) begin
          repeat (bt) @(negedge clk);
          fr[k] = uart_tx;
        end
        if (!mon_off) begin
          if (tx_exp_q.size() == 0) fail_now("tx_unexpected_frame");
          else check("tx_frame", 32'(fr), 32'({1'b1, tx_exp_q.pop_front(), 1'b0}));
        end
      end
      prev = uart_tx;
    end
  end

  // ---------------- bus driver (called at posedge+1) ----------------
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.bus_enable = 1'b1; bus.write_enable = 1'b1;
    bus.address = a; bus.data_in = d; bus.write_mask = m;
    @(posedge clk); #1;
    bus.bus_enable = 1'b0; bus.write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
    rd_name_q.push_back(nm);
    rd_exp_q.push_back(exp);
    bus.bus_enable = 1'b1; bus.write_enable = 1'b0;
    bus.address = a; bus.write_mask = 4'hF;
    @(posedge clk); #1;
    bus.bus_enable = 1'b0;
  endtask

  task automatic set_div(input logic [15:0] d);
    bus_write(4'hC, {16'hFFFF, d}, 4'b1100);
    bt_tb = (d < 2) ? 2 : int'(d);
  endtask

  task automatic wait_tx_done();
    int n = 0;
    while (tx_exp_q.size() != 0 && n < 20000) begin
      @(posedge clk); n++;
    end
    if (n >= 20000) begin
      fail_now("tx_drain_timeout");
      tx_exp_q.delete();
    end
    repeat (bt_tb + 2) @(posedge clk);
    #1;
  endtask

  // ---------------- RX reference model ----------------
  logic       m_valid, m_ovr, m_ferr;
  logic [7:0] m_byte;

  function automatic logic [31:0] m_status();
    return {27'b0, m_ferr, m_ovr, m_valid, 1'b1, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (bt_tb) @(posedge clk); #1;
    end
    uart_rx = 1'b1;
    repeat (2 * bt_tb + 4) @(posedge clk); #1;
    if (!stop_bit) m_ferr = 1'b1;
    else if (!m_valid) begin m_valid = 1'b1; m_byte = b; end
    else m_ovr = 1'b1;
  endtask

  task automatic rx_read(input string nm);
    logic [31:0] e;
    e = {23'b0, m_valid, m_byte};
    m_valid = 1'b0;
    bus_read(4'h4, e, nm);
  endtask

  task automatic sts_clear(input logic [31:0] d);
    bus_write(4'h8, d, 4'b1110);
    m_ovr  = m_ovr  & ~d[3];
    m_ferr = m_ferr & ~d[4];
  endtask

  // ---------------- main stimulus ----------------
  logic [15:0] div_choice [5] = '{16'd0, 16'd1, 16'd3, 16'd5, 16'd8};
  logic [15:0] rx_div     [3] = '{16'd4, 16'd8, 16'd16};

  initial begin
    reset_n = 1'b0; uart_rx = 1'b1; mon_off = 1'b0; bt_tb = 104;
    bus.bus_enable = 1'b0; bus.write_enable = 1'b0; bus.address = '0;
    bus.data_in = '0; bus.write_mask = 4'hF;
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_byte = '0;

    repeat (3) @(posedge clk); #1;
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_dout", bus.data_out, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus_read(4'h8, 32'h2, "rst_status");
    bus_read(4'hC, 32'd104, "rst_div");

    // lane 1 written, lane 0 keeps reset 0x68; then data_out must hold
    bus_write(4'hC, 32'hFFFF_1234, 4'b1101);
    bus_read(4'hC, 32'h0000_1268, "div_masked");
    repeat (3) @(posedge clk); #1;
    check("dout_hold", bus.data_out, 32'h0000_1268);
    bus_read(4'h0, 32'h0, "txdata_read");

    // lane 0 masked: no push
    set_div(16'd8);
    bus_write(4'h0, 32'h77, 4'b0001);
    repeat (2) @(posedge clk); #1;
    bus_read(4'h8, 32'h2, "tx_masked_lane");

    // single byte: line falls one cycle after push, idle again after 10 bit times
    tx_exp_q.push_back(8'hA5);
    bus_write(4'h0, 32'hA5, 4'b1110);
    check("tx_pre_fall", 32'(uart_tx), 32'd1);
    @(posedge clk); #1;
    check("tx_latency", 32'(uart_tx), 32'd0);
    repeat (79) @(posedge clk); #1;
    bus_read(4'h8, 32'h0, "tx_busy_at_80");
    bus_read(4'h8, 32'h2, "tx_idle_at_81");
    wait_tx_done();

    // bursts: idle transmitter absorbs DEPTH+1 back-to-back bytes (FIFO + shifter)
    for (int it = 0; it < 8; it++) begin
      int n;
      logic [7:0] b;
      if (it < 2) set_div(16'd8);
      else set_div(div_choice[$urandom_range(0, 4)]);
      n = (it == 0) ? 5 : (it == 1) ? 6 : $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        b = (it < 2) ? 8'(j + 1) : 8'($urandom);
        if (j < DEPTH + 1) tx_exp_q.push_back(b);
        bus_write(4'h0, {24'h0, b}, 4'b1110);
      end
      bus_read(4'h8, (n >= DEPTH + 1) ? 32'h1 : 32'h0, "burst_status");
      wait_tx_done();
    end

    // receive, pop, overrun, W1C
    set_div(16'd8);
    send_frame(8'h3C, 1'b1);
    rx_read("rx_first");
    rx_read("rx_second");
    send_frame(8'hA1, 1'b1);
    send_frame(8'hB2, 1'b1);
    bus_read(4'h8, m_status(), "ovr_status");
    rx_read("ovr_kept");
    sts_clear(32'h08);
    bus_read(4'h8, m_status(), "ovr_cleared");

    // framing error
    send_frame(8'h55, 1'b0);
    bus_read(4'h8, m_status(), "ferr_status");
    sts_clear(32'h10);
    bus_read(4'h8, m_status(), "ferr_cleared");

    // 2-cycle glitch is a false start; receiver must still take the next frame
    set_div(16'd16);
    uart_rx = 1'b0;
    repeat (2) @(posedge clk); #1;
    uart_rx = 1'b1;
    repeat (40) @(posedge clk); #1;
    bus_read(4'h8, m_status(), "glitch_status");
    send_frame(8'h99, 1'b1);
    rx_read("after_glitch");

    // random RX traffic against the model
    for (int it = 0; it < 10; it++) begin
      set_div(rx_div[$urandom_range(0, 2)]);
      send_frame(8'($urandom), ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 1) == 1) rx_read("rx_rand");
      bus_read(4'h8, m_status(), "rx_rand_status");
      if ($urandom_range(0, 2) == 0) sts_clear(32'($urandom_range(0, 31)));
    end

    // reset in the middle of a frame of zeros
    set_div(16'd8);
    mon_off = 1'b1;
    bus_write(4'h0, 32'h00, 4'b1110);
    repeat (20) @(posedge clk); #1;
    check("tx_mid_low", 32'(uart_tx), 32'd0);
    reset_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(uart_tx), 32'd1);
    m_valid = 0; m_ovr = 0; m_ferr = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus_read(4'h8, m_status(), "post_rst_status");
    bus_read(4'hC, 32'd104, "post_rst_div");
    repeat (4) @(posedge clk); #1;
    check("post_rst_tx", 32'(uart_tx), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
